// File: rtl/toggle_pulse_decoder_pkg.sv
// -----------------------------------------------------------------------------
// toggle_pulse_decoder_pkg
// Shared definitions for the toggle pulse decoder:
//   state_t        - event handshake FSM states (IDLE, PEND, OVR)
//   CNT_W_DEFAULT  - default width of the event counter
// -----------------------------------------------------------------------------
package toggle_pulse_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no event held
    PEND = 2'd1,  // one event waiting for ack
    OVR  = 2'd2   // event waiting for ack, at least one more arrived meanwhile
  } state_t;

  localparam int CNT_W_DEFAULT = 8;

endpackage : toggle_pulse_decoder_pkg

// File: rtl/toggle_sync.sv
// -----------------------------------------------------------------------------
// toggle_sync
// Input stage of the toggle pulse decoder: brings t_in into the clock domain,
// keeps the previous sample and raises a one-cycle pulse on every level change.
//
// Build option: define TOGGLE_DEC_SYNC_EN to put a two-flop synchronizer in
// front of `cur` (needed when t_in is asynchronous). Without it t_in is
// registered once straight into `cur` and latency is one cycle shorter.
//
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   t_in   in   toggle-encoded level from the remote T-FF
//   cur    out  registered (synchronized) sample of t_in
//   pulse  out  one-cycle strobe per detected level change
// -----------------------------------------------------------------------------
module toggle_sync (
  input  logic clock,
  input  logic reset,
  input  logic t_in,
  output logic cur,
  output logic pulse
);

  logic prev;
  logic armed;
  logic cur_d;        // value `cur` loads at the next edge
  logic cur_d_valid;  // cur_d is a real t_in sample, not a reset leftover

`ifdef TOGGLE_DEC_SYNC_EN
  logic s1;
  logic s1_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1       <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1       <= t_in;
      s1_valid <= 1'b1;
    end
  end

  assign cur_d       = s1;
  assign cur_d_valid = s1_valid;
`else
  assign cur_d       = t_in;
  assign cur_d_valid = 1'b1;
`endif

  // While disarmed, prev tracks the value cur is about to load, so the first
  // real sample after reset is compared with itself and cannot look like a
  // toggle. Arming waits until that sample has made it through the stage,
  // which keeps a t_in held at 1 through reset silent even with the
  // synchronizer (whose flops come out of reset at 0).
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: all state here uses non-blocking assignments so that prev sees
    // the old value of cur in the same edge, exactly as the flops would.
    if (reset) begin
      cur   <= 1'b0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      cur <= cur_d;
      if (!armed) begin
        prev  <= cur_d;
        armed <= cur_d_valid;
      end else begin
        prev <= cur;
      end
    end
  end

  assign pulse = armed & (cur ^ prev);

endmodule : toggle_sync

// File: rtl/toggle_pulse_decoder.sv
// -----------------------------------------------------------------------------
// toggle_pulse_decoder
// Recovers level changes on a toggle-encoded wire as single-cycle pulses,
// holds each event in a pending/ack handshake, flags overruns and counts
// events since reset.
//
// Build option: TOGGLE_DEC_SYNC_EN (see toggle_sync) selects the two-flop
// synchronizer input stage.
//
// Parameters:
//   CNT_W     width of the event counter
//   SATURATE  0 = counter wraps, 1 = counter sticks at all-ones
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   t_in     in   toggle-encoded level (may be asynchronous)
//   ack      in   consumer acknowledge, sampled on the rising edge
//   level    out  recovered copy of t_in
//   pulse    out  one-cycle strobe per detected toggle
//   pending  out  an unacknowledged event is held
//   overrun  out  a toggle arrived while an event was pending
//   count    out  toggles detected since reset
// -----------------------------------------------------------------------------
module toggle_pulse_decoder
  import toggle_pulse_decoder_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             t_in,
  input  logic             ack,
  output logic             level,
  output logic             pulse,
  output logic             pending,
  output logic             overrun,
  output logic [CNT_W-1:0] count
);

  state_t state;

  toggle_sync u_sync (
    .clock (clock),
    .reset (reset),
    .t_in  (t_in),
    .cur   (level),
    .pulse (pulse)
  );

  // Handshake FSM. pending/overrun are registered alongside the state so the
  // outputs are glitch-free and change only at the edge that moves the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pulse) begin
            state   <= PEND;
            pending <= 1'b1;
          end
        end
        PEND: begin
          if (ack && !pulse) begin
            state   <= IDLE;
            pending <= 1'b0;
          end else if (!ack && pulse) begin
            state   <= OVR;
            overrun <= 1'b1;
          end
          // ack together with a new pulse: the new event replaces the old one
        end
        OVR: begin
          if (ack) begin
            state   <= pulse ? PEND : IDLE;
            pending <= pulse;
            overrun <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= 1'b0;
          overrun <= 1'b0;
        end
      endcase
    end
  end

  // Event counter, independent of the handshake state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (pulse) begin
      if (!(SATURATE && (&count))) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule : toggle_pulse_decoder

// File: tb/tb_toggle_pulse_decoder.sv
// -----------------------------------------------------------------------------
// tb_toggle_pulse_decoder
// Directed self-checking bench for toggle_pulse_decoder. Two instances share
// the stimulus: dut (CNT_W=4, wrapping) and dut_sat (CNT_W=4, saturating).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_toggle_pulse_decoder;

`ifdef TOGGLE_DEC_SYNC_EN
  localparam int LAT = 2;  // edges from t_in change until pulse is high
`else
  localparam int LAT = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       t_in  = 1'b0;
  logic       ack   = 1'b0;

  logic       level, pulse, pending, overrun;
  logic [3:0] count;
  logic       level_s, pulse_s, pending_s, overrun_s;
  logic [3:0] count_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  toggle_pulse_decoder #(.CNT_W(4), .SATURATE(1'b0)) dut (
    .clock   (clock),
    .reset   (reset),
    .t_in    (t_in),
    .ack     (ack),
    .level   (level),
    .pulse   (pulse),
    .pending (pending),
    .overrun (overrun),
    .count   (count)
  );

  toggle_pulse_decoder #(.CNT_W(4), .SATURATE(1'b1)) dut_sat (
    .clock   (clock),
    .reset   (reset),
    .t_in    (t_in),
    .ack     (ack),
    .level   (level_s),
    .pulse   (pulse_s),
    .pending (pending_s),
    .overrun (overrun_s),
    .count   (count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset with the current t_in level, then let the input stage arm.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
  endtask

  // Change t_in, expect the pulse exactly LAT edges later for one cycle.
  // ack_on_pulse drives ack during the pulse cycle only.
  task automatic send_toggle(input string tag, input logic v, input logic ack_on_pulse);
    t_in = v;
    repeat (LAT) tick();
    check({tag, "_pulse_hi"}, pulse, 1'b1);
    ack = ack_on_pulse;
    tick();
    ack = 1'b0;
    check({tag, "_pulse_lo"}, pulse, 1'b0);
  endtask

  initial begin
    int npulse;

    // ---- 1: static t_in=1 through reset -> no event --------------------------
    t_in  = 1'b1;
    reset = 1'b1;
    #12;
    check("rst_level",   level,   1'b0);
    check("rst_pulse",   pulse,   1'b0);
    check("rst_pending", pending, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_count",   count,   4'd0);
    tick();
    reset  = 1'b0;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pulse) npulse++;
      if (i == 1) check("static_level_edge2", level, 1'b1);
    end
    check("static_no_pulse", npulse, 0);
    check("static_count",    count,  4'd0);
    check("static_level",    level,  1'b1);

    // ---- 2: two toggles with acks, latency check -----------------------------
    t_in = 1'b0;
    do_reset();
    for (int n = 0; n < 2; n++) begin
      send_toggle("tog", (n == 0), 1'b0);
      check("tog_pending_rise", pending, 1'b1);
      check("tog_count",        count,   n + 1);
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("tog_pending_fall", pending, 1'b0);
      check("tog_overrun",      overrun, 1'b0);
    end
    check("tog_count_final", count, 4'd2);

    // ---- 3: two toggles without ack -> OVR, then ack clears ------------------
    do_reset();
    send_toggle("ovr1", 1'b1, 1'b0);
    tick();
    send_toggle("ovr2", 1'b0, 1'b0);
    check("ovr_pending", pending, 1'b1);
    check("ovr_overrun", overrun, 1'b1);
    check("ovr_count",   count,   4'd2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ovr_ack_pending", pending, 1'b0);
    check("ovr_ack_overrun", overrun, 1'b0);

    // ---- 4: ack coincident with new pulse in PEND ----------------------------
    do_reset();
    send_toggle("pack1", 1'b1, 1'b0);
    tick();
    send_toggle("pack2", 1'b0, 1'b1);
    check("pack_pending", pending, 1'b1);
    check("pack_overrun", overrun, 1'b0);
    check("pack_count",   count,   4'd2);

    // ack coincident with new pulse in OVR -> PEND, overrun clears
    send_toggle("oack1", 1'b1, 1'b0);
    check("oack_in_ovr", overrun, 1'b1);
    send_toggle("oack2", 1'b0, 1'b1);
    check("oack_pending", pending, 1'b1);
    check("oack_overrun", overrun, 1'b0);
    check("oack_count",   count,   4'd4);

    // ---- 5: 17 toggles, wrap vs saturate -------------------------------------
    do_reset();
    for (int n = 0; n < 17; n++) begin
      send_toggle("cnt", ~t_in, 1'b0);
      if (n == 15) begin
        check("wrap_at16", count,   4'd0);
        check("sat_at16",  count_s, 4'd15);
      end
    end
    check("wrap_count17", count,   4'd1);
    check("sat_count17",  count_s, 4'd15);

    // ---- 6: reset while a toggle is in flight --------------------------------
    t_in = 1'b0;
    do_reset();
    t_in = 1'b1;
    repeat (LAT - 1) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_pulse",   pulse,   1'b0);
    check("mid_rst_level",   level,   1'b0);
    check("mid_rst_pending", pending, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    check("mid_rst_count",   count,   4'd0);
    tick();
    reset  = 1'b0;
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pulse) npulse++;
    end
    check("mid_rst_no_pulse", npulse,  0);
    check("mid_rst_count2",   count,   4'd0);
    check("mid_rst_pending2", pending, 1'b0);
    check("mid_rst_level2",   level,   1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_toggle_pulse_decoder
